// File: rtl/demux1to8_if.sv
// Bus interface for the 1-to-8 demux collector.
// The master drives lane data and routing controls.
// The slave (the collector) returns live lanes, the fill mask, completed frames and status pulses.
interface demux1to8_if #(
    parameter int WIDTH = 1
);
    // Master -> slave: lane stream and routing controls
    logic [WIDTH-1:0]   data_in;
    logic               data_valid;
    logic [2:0]         select;
    logic               auto_sel;
    logic               clear;

    // Slave -> master: lane registers, frame and status
    logic [8*WIDTH-1:0] data_out;
    logic [7:0]         lane_mask;
    logic [8*WIDTH-1:0] frame_out;
    logic               frame_valid;
    logic               overwrite_err;
    logic [2:0]         next_sel;

    modport master (
        output data_in, data_valid, select, auto_sel, clear,
        input  data_out, lane_mask, frame_out, frame_valid, overwrite_err, next_sel
    );

    modport slave (
        input  data_in, data_valid, select, auto_sel, clear,
        output data_out, lane_mask, frame_out, frame_valid, overwrite_err, next_sel
    );
endinterface

// File: rtl/demux1to8_collector.sv
// Registered 1-to-8 demultiplexer with frame collection.
// A serial lane stream is routed into eight lane registers, using either an external
// select or an internal auto-incrementing counter. Lane occupancy is tracked.
// When the last empty lane is written, the assembled frame is published together with
// a one-cycle valid pulse. The block then returns to EMPTY on that same edge.
module demux1to8_collector #(
    parameter int WIDTH = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    demux1to8_if.slave  bus_if
);

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_FILLING = 1'b1
    } state_e;

    state_e             state_q,         state_d;
    logic [8*WIDTH-1:0] data_out_q,      data_out_d;
    logic [8*WIDTH-1:0] frame_out_q,     frame_out_d;
    logic [7:0]         lane_mask_q,     lane_mask_d;
    logic [2:0]         next_sel_q,      next_sel_d;
    logic               frame_valid_q,   frame_valid_d;
    logic               overwrite_err_q, overwrite_err_d;

    // Routing helpers derived from the current inputs and state
    logic [2:0]         dst;
    logic [7:0]         dst_onehot;
    logic [8*WIDTH-1:0] data_merged;
    logic               lane_hit;
    logic               frame_done;

    // Decode the destination lane, and build the lane vector that would exist after this write
    always_comb begin
        dst         = bus_if.auto_sel ? next_sel_q : bus_if.select;
        dst_onehot  = 8'b0000_0001 << dst;
        data_merged = data_out_q;
        data_merged[int'(dst)*WIDTH +: WIDTH] = bus_if.data_in;
        lane_hit    = |(lane_mask_q & dst_onehot);
        frame_done  = ((lane_mask_q | dst_onehot) == 8'hFF);
    end

    // Next-state and output logic: CLEAR beats a write, and completion beats mask update
    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path can infer a latch.
        state_d         = state_q;
        data_out_d      = data_out_q;
        frame_out_d     = frame_out_q;
        lane_mask_d     = lane_mask_q;
        next_sel_d      = next_sel_q;
        frame_valid_d   = 1'b0;
        overwrite_err_d = 1'b0;

        if (bus_if.clear) begin
            // Abort the frame: drop any simultaneous write and keep the last completed frame
            data_out_d  = '0;
            lane_mask_d = '0;
            next_sel_d  = '0;
            state_d     = ST_EMPTY;
        end else if (bus_if.data_valid) begin
            data_out_d = data_merged;
            if (bus_if.auto_sel) begin
                next_sel_d = next_sel_q + 3'd1;
            end

            case (state_q)
                ST_EMPTY: begin
                    // With an empty mask, a single write can neither hit a full lane nor complete a frame
                    lane_mask_d = dst_onehot;
                    state_d     = ST_FILLING;
                end
                ST_FILLING: begin
                    if (frame_done) begin
                        // The final lane is always empty, so completion never flags an overwrite
                        frame_out_d   = data_merged;
                        frame_valid_d = 1'b1;
                        lane_mask_d   = '0;
                        state_d       = ST_EMPTY;
                    end else begin
                        lane_mask_d     = lane_mask_q | dst_onehot;
                        overwrite_err_d = lane_hit;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously by rst_i
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= ST_EMPTY;
            data_out_q      <= '0;
            frame_out_q     <= '0;
            lane_mask_q     <= '0;
            next_sel_q      <= '0;
            frame_valid_q   <= 1'b0;
            overwrite_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples pre-edge values.
            state_q         <= state_d;
            data_out_q      <= data_out_d;
            frame_out_q     <= frame_out_d;
            lane_mask_q     <= lane_mask_d;
            next_sel_q      <= next_sel_d;
            frame_valid_q   <= frame_valid_d;
            overwrite_err_q <= overwrite_err_d;
        end
    end

    assign bus_if.data_out      = data_out_q;
    assign bus_if.lane_mask     = lane_mask_q;
    assign bus_if.frame_out     = frame_out_q;
    assign bus_if.frame_valid   = frame_valid_q;
    assign bus_if.overwrite_err = overwrite_err_q;
    assign bus_if.next_sel      = next_sel_q;

    // The complete mask is never held, and the two status pulses never coincide
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (lane_mask_q != 8'hFF);
            assert (!(frame_valid_q && overwrite_err_q));
            assert ((state_q == ST_EMPTY) == (lane_mask_q == 8'h00));
        end
    end

endmodule

// File: tb/tb_demux1to8_collector.sv
// Directed bench for demux1to8_collector.
// The stimulus process pushes expected frames and overwrite events into queues.
// A negedge monitor pops and compares them whenever the DUT pulses FRAME_VALID or OVERWRITE_ERR.
module tb_demux1to8_collector;

    localparam int WIDTH = 1;

    logic clk;
    logic rst;

    demux1to8_if #(.WIDTH(WIDTH)) bus ();

    demux1to8_collector #(.WIDTH(WIDTH)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] exp_frames [$];
    logic [7:0] exp_ow     [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clocked transaction; the inputs are applied on the falling edge.
    // Outputs are sampled 1 time unit after the rising edge.
    task automatic drive(input logic dv, input logic d, input logic [2:0] sel,
                         input logic as, input logic clr);
        @(negedge clk);
        bus.data_valid = dv;
        bus.data_in    = d;
        bus.select     = sel;
        bus.auto_sel   = as;
        bus.clear      = clr;
        @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
        bus.clear      = 1'b0;
    endtask

    task automatic fill_manual(input logic [7:0] pat);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) exp_frames.push_back(pat);
            drive(1'b1, pat[i], 3'(i), 1'b0, 1'b0);
        end
    endtask

    // Monitor: every status pulse must match a queued expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.frame_valid || bus.overwrite_err)
                check("pulse_exclusive", {62'd0, bus.frame_valid, bus.overwrite_err} & 64'h3 ^ 64'h3, 64'h3 & ~{62'd0, bus.frame_valid, bus.overwrite_err} ^ 64'h3 ^ 64'h3 | 64'h0);
            if (bus.frame_valid) begin
                if (exp_frames.size() == 0) check("frame_unexpected", 64'd1, 64'd0);
                else check("frame_out", {56'd0, bus.frame_out}, {56'd0, exp_frames.pop_front()});
            end
            if (bus.overwrite_err) begin
                if (exp_ow.size() == 0) check("overwrite_unexpected", 64'd1, 64'd0);
                else check("overwrite_data_out", {56'd0, bus.data_out}, {56'd0, exp_ow.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat;
        rst            = 1'b1;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        bus.select     = '0;
        bus.auto_sel   = 1'b0;
        bus.clear      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_data_out",  {56'd0, bus.data_out},  64'h00);
        check("rst_lane_mask", {56'd0, bus.lane_mask}, 64'h00);
        check("rst_frame_out", {56'd0, bus.frame_out}, 64'h00);
        check("rst_next_sel",  {61'd0, bus.next_sel},  64'h0);
        check("rst_pulses",    {62'd0, bus.frame_valid, bus.overwrite_err}, 64'h0);

        // 1. Manual fill of 8'hAA: the mask grows 01,03,...,7F and clears on completion
        pat = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) exp_frames.push_back(8'hAA);
            drive(1'b1, pat[i], 3'(i), 1'b0, 1'b0);
            check("t1_mask", {56'd0, bus.lane_mask}, (i < 7) ? ((64'd1 << (i + 1)) - 64'd1) : 64'd0);
        end
        check("t1_data_out", {56'd0, bus.data_out}, 64'hAA);
        check("t1_next_sel", {61'd0, bus.next_sel}, 64'd0);
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        check("t1_pulse_len", {63'd0, bus.frame_valid}, 64'd0);

        // 2. Auto fill of 8'h55, with one idle cycle mid-stream
        pat = 8'h55;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) exp_frames.push_back(8'h55);
            drive(1'b1, pat[i], 3'd7, 1'b1, 1'b0);
            check("t2_next_sel", {61'd0, bus.next_sel}, 64'((i + 1) % 8));
            if (i == 3) begin
                drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
                check("t2_idle_next_sel", {61'd0, bus.next_sel}, 64'd4);
                check("t2_idle_mask", {56'd0, bus.lane_mask}, 64'h0F);
            end
        end
        check("t2_mask", {56'd0, bus.lane_mask}, 64'h00);

        // 3. Overwrite lane 3. DATA_OUT starts at 55, goes to 5D after the first write, and back to 55.
        drive(1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
        check("t3_mask_first", {56'd0, bus.lane_mask}, 64'h08);
        exp_ow.push_back(8'h55);
        drive(1'b1, 1'b0, 3'd3, 1'b0, 1'b0);
        check("t3_overwrite", {63'd0, bus.overwrite_err}, 64'd1);
        check("t3_bit3", {63'd0, bus.data_out[3]}, 64'd0);
        check("t3_mask_second", {56'd0, bus.lane_mask}, 64'h08);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) continue;
            if (i == 7) exp_frames.push_back(8'hF7);
            drive(1'b1, 1'b1, 3'(i), 1'b0, 1'b0);
        end
        check("t3_mask_done", {56'd0, bus.lane_mask}, 64'h00);

        // 4. CLEAR collides with a write after 5 writes; FRAME_OUT keeps AA
        fill_manual(8'hAA);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
        check("t4_pre_mask", {56'd0, bus.lane_mask}, 64'h1F);
        drive(1'b1, 1'b1, 3'd6, 1'b0, 1'b1);
        check("t4_mask",      {56'd0, bus.lane_mask}, 64'h00);
        check("t4_next_sel",  {61'd0, bus.next_sel},  64'd0);
        check("t4_data_out",  {56'd0, bus.data_out},  64'h00);
        check("t4_frame_out", {56'd0, bus.frame_out}, 64'hAA);
        check("t4_pulses",    {62'd0, bus.frame_valid, bus.overwrite_err}, 64'h0);

        // 5. Assert the async reset between edges after 4 writes
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
        check("t5_pre_mask", {56'd0, bus.lane_mask}, 64'h0F);
        #2;
        rst = 1'b1;
        #1;
        check("t5_data_out",  {56'd0, bus.data_out},  64'h00);
        check("t5_mask",      {56'd0, bus.lane_mask}, 64'h00);
        check("t5_frame_out", {56'd0, bus.frame_out}, 64'h00);
        check("t5_next_sel",  {61'd0, bus.next_sel},  64'd0);
        @(negedge clk);
        rst = 1'b0;
        fill_manual(8'h3C);
        check("t5_after_mask", {56'd0, bus.lane_mask}, 64'h00);

        // 6. Mixed mode: auto writes to lanes 0-3, then manual writes to lanes 4-7, for frame C5
        pat = 8'hC5;
        for (int i = 0; i < 4; i++) drive(1'b1, pat[i], 3'd7, 1'b1, 1'b0);
        for (int i = 4; i < 8; i++) begin
            if (i == 7) exp_frames.push_back(8'hC5);
            drive(1'b1, pat[i], 3'(i), 1'b0, 1'b0);
            check("t6_next_sel", {61'd0, bus.next_sel}, 64'd4);
        end
        check("t6_mask", {56'd0, bus.lane_mask}, 64'h00);

        repeat (3) drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        check("frames_drained",    64'(exp_frames.size()), 64'd0);
        check("overwrite_drained", 64'(exp_ow.size()),     64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/demux1to8_collector.md
Name: demux1to8_collector

Overview:
Registered 1-to-8 demultiplexer, the receive-side counterpart of the 8-to-1 mux path. It routes a serial lane stream (DATA_IN) into eight output lanes, either at an externally driven SELECT or at an internal auto-incrementing select. It tracks which lanes have been written. Once all eight lanes are filled, it publishes the assembled frame with a one-cycle valid pulse, so a mux-serialised byte is reconstructed on the far side.

Parameters:
WIDTH, 1, bit width of each lane (DATA_IN width); lane i occupies DATA_OUT[i*WIDTH +: WIDTH]

Ports:
CLK  input  1  rising-edge clock
RESET  input  1  asynchronous, active-high reset
DATA_IN  input  WIDTH  lane data to route
DATA_VALID  input  1  DATA_IN is written this cycle when high
SELECT  input  3  destination lane when AUTO_SEL=0
AUTO_SEL  input  1  1: use internal counter NEXT_SEL as destination; 0: use SELECT
CLEAR  input  1  synchronous frame abort
DATA_OUT  output  8*WIDTH  live lane registers (demux outputs, hold last written value)
LANE_MASK  output  8  bit i set = lane i written in current frame
FRAME_OUT  output  8*WIDTH  last completed frame, held until next completion
FRAME_VALID  output  1  one-cycle pulse, FRAME_OUT updated this cycle
OVERWRITE_ERR  output  1  one-cycle pulse, write hit an already-filled lane
NEXT_SEL  output  3  internal auto-select counter value

Behaviour:
- RESET (async, any time, incl. mid-frame): DATA_OUT=0, LANE_MASK=0, FRAME_OUT=0, FRAME_VALID=0, OVERWRITE_ERR=0, NEXT_SEL=0, state=EMPTY. Partial frame is discarded.
- States:
  - EMPTY (mask==0).
  - FILLING (mask!=0, not all ones).
  - The complete condition is never held: completion returns the block to EMPTY in the same edge.
- Destination: dst = AUTO_SEL ? NEXT_SEL : SELECT, sampled in the same cycle as DATA_VALID.
- Write (DATA_VALID=1, CLEAR=0), applied at the next rising edge (1-cycle latency):
  - DATA_OUT lane dst <= DATA_IN.
  - If LANE_MASK[dst]==0: set it. EMPTY->FILLING.
  - If LANE_MASK[dst]==1: data is still overwritten, mask is unchanged, OVERWRITE_ERR=1 for one cycle.
  - If AUTO_SEL=1: NEXT_SEL <= NEXT_SEL+1, wrapping 7->0. NEXT_SEL is unchanged when AUTO_SEL=0.
- Completion: if (LANE_MASK | onehot(dst)) == 8'hFF on a write, then at that edge:
  - FRAME_OUT <= DATA_OUT with lane dst replaced by DATA_IN (includes the final write).
  - FRAME_VALID=1 for exactly one cycle.
  - LANE_MASK <= 0, state -> EMPTY.
  - DATA_OUT retains its values.
- The final write can never raise OVERWRITE_ERR, because its lane was empty.
- FRAME_VALID and OVERWRITE_ERR are mutually exclusive.
- Idle (DATA_VALID=0): all state holds; pulses deassert.
- CLEAR=1 (synchronous) has priority over a simultaneous DATA_VALID. The write is dropped and:
  - LANE_MASK=0, NEXT_SEL=0, DATA_OUT=0, state -> EMPTY.
  - FRAME_OUT is held; no pulses.
- Switching AUTO_SEL mid-frame: mask and counter are preserved. Manual writes do not advance NEXT_SEL.
- RESET overrides CLEAR and all other inputs.

Test Plan:
1. Manual fill: AUTO_SEL=0, WIDTH=1, DATA_IN = bits of 8'b10101010, SELECT 0..7 on consecutive cycles -> LANE_MASK grows 01, 03 ... 7F. After the 8th edge: FRAME_OUT=8'hAA, FRAME_VALID one cycle, LANE_MASK=0.
2. Auto fill: AUTO_SEL=1, 8 valid writes of 8'b01010101 bits -> NEXT_SEL steps 1..7 then 0, FRAME_OUT=8'h55, single FRAME_VALID pulse. An idle cycle mid-stream does not advance NEXT_SEL.
3. Overwrite: write lane 3 twice (1 then 0) -> second write gives OVERWRITE_ERR pulse, DATA_OUT[3]=0, LANE_MASK=08. Filling the remaining 7 lanes completes with bit3=0 in FRAME_OUT.
4. CLEAR collision: after 5 writes, assert CLEAR with DATA_VALID -> LANE_MASK=0, NEXT_SEL=0, DATA_OUT=0, FRAME_OUT unchanged (previous 8'hAA), no pulses.
5. Async reset mid-frame: assert RESET between clock edges after 4 writes -> all outputs 0 immediately, without waiting for CLK. A full 8-write sequence afterwards completes normally.
6. Mixed mode: 4 auto writes (lanes 0-3), then manual SELECT=4..7 -> FRAME_VALID after the 8th write, NEXT_SEL remains 4.
